// File: rtl/color_config_responder_pkg.sv
// Shared definitions for the color-configuration responder and its
// VGA-path helpers.
// Contents: parameter defaults, quadrant address constants, the
// handshake state encoding, and a helper that forms the quadrant
// address from the down/right flags.
package color_config_responder_pkg;

    localparam int C_ADDR_WIDTH_DEF = 2;
    localparam int C_DATA_WIDTH_DEF = 12;
    localparam int H_ACTIVE_DEF     = 640;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int ACK_DELAY_DEF    = 2;

    localparam logic [1:0] QUAD_LU = 2'b00;
    localparam logic [1:0] QUAD_RU = 2'b01;
    localparam logic [1:0] QUAD_RD = 2'b11;
    localparam logic [1:0] QUAD_LD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        DROP  = 2'd2
    } hs_state_t;

    function automatic logic [1:0] quad_addr(input logic down, input logic right);
        return {down, right};
    endfunction

endpackage

// File: rtl/color_quadrant_locator.sv
// Tracks the pixel position from the sync/enable strobes and reports
// which screen quadrant the current pixel lies in.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   pixel_en                          advances X
//   hsync, vsync                      line/frame markers (rising edge used)
//   vertical_split, horizontal_split  enable left/right and up/down split
//   quad_sel                          {down, right} of the current position
//   frame_start                       registered VSync rising edge
module color_quadrant_locator
    import color_config_responder_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pixel_en,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       vertical_split,
    input  logic       horizontal_split,
    output logic [1:0] quad_sel,
    output logic       frame_start
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] X_HALF = XW'(H_ACTIVE / 2);
    localparam logic [YW-1:0] Y_HALF = YW'(V_ACTIVE / 2);

    logic          hsync_prev;
    logic          vsync_prev;
    logic          hsync_edge;
    logic          vsync_edge;
    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic          right;
    logic          down;

    assign hsync_edge = hsync & ~hsync_prev;
    assign vsync_edge = vsync & ~vsync_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_prev  <= 1'b0;
            vsync_prev  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync_prev  <= hsync;
            vsync_prev  <= vsync;
            frame_start <= vsync_edge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
        end else if (hsync_edge) begin
            x_pos <= '0;
        end else if (pixel_en && (x_pos != X_MAX)) begin
            x_pos <= x_pos + XW'(1);
        end
    end

    // A frame marker wins over a line marker arriving on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_pos <= '0;
        end else if (vsync_edge) begin
            y_pos <= '0;
        end else if (hsync_edge && (y_pos != Y_MAX)) begin
            y_pos <= y_pos + YW'(1);
        end
    end

    assign right    = vertical_split & (x_pos >= X_HALF);
    assign down     = horizontal_split & (y_pos >= Y_HALF);
    assign quad_sel = quad_addr(down, right);

endmodule

// File: rtl/color_config_responder.sv
// Responder side of the color-configuration handshake. Accepts one
// quadrant color write per C_Valid assertion, acknowledges it after a
// fixed delay, and double-buffers the four colors so the display only
// changes at frame boundaries.
// Ports:
//   Clk, Rst                       clock, async active-low reset
//   C_Valid, C_Addr, C_Data        write request from the color manager
//   C_Rdy                          one-cycle commit acknowledge
//   Vertical_Split, Horizontal_Split  quadrant split enables
//   Pixel_En, HSync, VSync         position strobes
//   Pixel_Color                    registered color of current pixel
//   Write_Count                    committed writes, wrapping
//
// state | meaning
// IDLE  | waiting for C_Valid; captures address/data on request
// DELAY | counting down to the commit; commits and pulses C_Rdy at 0
// DROP  | waiting for C_Valid to fall before accepting another write
module color_config_responder
    import color_config_responder_pkg::*;
#(
    parameter int C_ADDR_WIDTH = C_ADDR_WIDTH_DEF,
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int ACK_DELAY    = ACK_DELAY_DEF
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    C_Valid,
    input  logic [C_ADDR_WIDTH-1:0] C_Addr,
    input  logic [C_DATA_WIDTH-1:0] C_Data,
    output logic                    C_Rdy,
    input  logic                    Vertical_Split,
    input  logic                    Horizontal_Split,
    input  logic                    Pixel_En,
    input  logic                    HSync,
    input  logic                    VSync,
    output logic [C_DATA_WIDTH-1:0] Pixel_Color,
    output logic [7:0]              Write_Count
);

    localparam int NQ = 1 << C_ADDR_WIDTH;

    hs_state_t               state;
    hs_state_t               state_nxt;
    logic                    capture;
    logic                    commit;
    logic [3:0]              delay_cnt;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] data_q;
    logic [C_DATA_WIDTH-1:0] working [NQ];
    logic [C_DATA_WIDTH-1:0] shadow  [NQ];
    logic [1:0]              quad_sel;
    logic                    frame_start;

    color_quadrant_locator #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_locator (
        .clk              (Clk),
        .rst_n            (Rst),
        .pixel_en         (Pixel_En),
        .hsync            (HSync),
        .vsync            (VSync),
        .vertical_split   (Vertical_Split),
        .horizontal_split (Horizontal_Split),
        .quad_sel         (quad_sel),
        .frame_start      (frame_start)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (C_Valid) begin
                    capture   = 1'b1;
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                if (delay_cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (!C_Valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter is loaded with ACK_DELAY-1 so the commit edge lands exactly
    // ACK_DELAY edges after the capture edge.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            addr_q      <= '0;
            data_q      <= '0;
            delay_cnt   <= '0;
            C_Rdy       <= 1'b0;
            Write_Count <= '0;
        end else begin
            C_Rdy <= commit;
            if (capture) begin
                addr_q    <= C_Addr;
                data_q    <= C_Data;
                delay_cnt <= 4'(ACK_DELAY - 1);
            end else if ((state == DELAY) && (delay_cnt != 4'd0)) begin
                delay_cnt <= delay_cnt - 4'd1;
            end
            if (commit) Write_Count <= Write_Count + 8'd1;
        end
    end

    // A commit and a shadow copy on the same edge: the shadow picks up the
    // pre-write working value, so the new color waits for the next frame.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < NQ; i++) begin
                working[i] <= '0;
                shadow[i]  <= '0;
            end
            Pixel_Color <= '0;
        end else begin
            if (commit) working[addr_q] <= data_q;
            if (frame_start) begin
                for (int i = 0; i < NQ; i++) shadow[i] <= working[i];
            end
            Pixel_Color <= shadow[quad_sel];
        end
    end

endmodule

// File: tb/tb_color_config_responder.sv
module tb_color_config_responder;

    localparam int ACK_DELAY = 2;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        C_Valid;
    logic [1:0]  C_Addr;
    logic [11:0] C_Data;
    logic        C_Rdy;
    logic        Vertical_Split;
    logic        Horizontal_Split;
    logic        Pixel_En;
    logic        HSync;
    logic        VSync;
    logic [11:0] Pixel_Color;
    logic [7:0]  Write_Count;

    color_config_responder #(
        .C_ADDR_WIDTH (2),
        .C_DATA_WIDTH (12),
        .H_ACTIVE     (H_ACTIVE),
        .V_ACTIVE     (V_ACTIVE),
        .ACK_DELAY    (ACK_DELAY)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .C_Valid          (C_Valid),
        .C_Addr           (C_Addr),
        .C_Data           (C_Data),
        .C_Rdy            (C_Rdy),
        .Vertical_Split   (Vertical_Split),
        .Horizontal_Split (Horizontal_Split),
        .Pixel_En         (Pixel_En),
        .HSync            (HSync),
        .VSync            (VSync),
        .Pixel_Color      (Pixel_Color),
        .Write_Count      (Write_Count)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: working colors, displayed colors, commit count.
    int model_work   [4];
    int model_shadow [4];
    int model_wc;

    typedef struct {
        bit vs;
        bit hs;
        int xs;
        int ys;
        int exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int expected_pixel(input bit vs, input bit hs, input int xs, input int ys);
        int x, y, right, down;
        x     = (xs > H_ACTIVE - 1) ? H_ACTIVE - 1 : xs;
        y     = (ys > V_ACTIVE - 1) ? V_ACTIVE - 1 : ys;
        right = (vs && x >= H_ACTIVE / 2) ? 1 : 0;
        down  = (hs && y >= V_ACTIVE / 2) ? 1 : 0;
        return model_shadow[down * 2 + right];
    endfunction

    // Full write transaction; address/data are scrambled after capture.
    task automatic do_write(input int a, input int d, input int hold);
        int lat;
        int pulses;
        C_Addr  = 2'(a);
        C_Data  = 12'(d);
        C_Valid = 1'b1;
        tick();
        C_Addr  = ~2'(a);
        C_Data  = ~12'(d);
        lat     = -1;
        pulses  = 0;
        for (int k = 1; k <= ACK_DELAY + hold; k++) begin
            tick();
            if (C_Rdy) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        check("wr_latency", lat, ACK_DELAY);
        check("wr_pulses", pulses, 1);
        C_Valid = 1'b0;
        ticks(2);
        model_work[a] = d;
        model_wc      = (model_wc + 1) % 256;
        check("wr_count", int'(Write_Count), model_wc);
    endtask

    task automatic vsync_pulse();
        VSync = 1'b1;
        tick();
        VSync = 1'b0;
        ticks(3);
        model_shadow = model_work;
    endtask

    task automatic goto_pos(input int xs, input int ys);
        vsync_pulse();
        for (int i = 0; i < ys; i++) begin
            HSync = 1'b1;
            tick();
            HSync = 1'b0;
            tick();
        end
        Pixel_En = 1'b1;
        ticks(xs);
        Pixel_En = 1'b0;
        ticks(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int lat;
        Rst = 1'b0;
        C_Valid = 1'b0; C_Addr = '0; C_Data = '0;
        Vertical_Split = 1'b0; Horizontal_Split = 1'b0;
        Pixel_En = 1'b0; HSync = 1'b0; VSync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_work[i]   = 0;
            model_shadow[i] = 0;
        end
        model_wc = 0;

        vecs[0]  = '{1, 1, 700,   0, 12'h0F0};
        vecs[1]  = '{1, 1,   0, 479, 12'hFFF};
        vecs[2]  = '{1, 1, 320, 240, 12'hF00};
        vecs[3]  = '{1, 1, 319, 239, 12'h00F};
        vecs[4]  = '{1, 1, 320, 239, 12'h0F0};
        vecs[5]  = '{1, 1, 319, 240, 12'hFFF};
        vecs[6]  = '{1, 1, 700, 500, 12'hF00};
        vecs[7]  = '{0, 0, 639, 479, 12'h00F};
        vecs[8]  = '{0, 0, 320, 240, 12'h00F};
        vecs[9]  = '{1, 0, 400, 400, 12'h0F0};
        vecs[10] = '{0, 1, 400, 400, 12'hFFF};
        vecs[11] = '{0, 1, 639,   0, 12'h00F};

        ticks(3);
        check("rst_rdy", int'(C_Rdy), 0);
        check("rst_count", int'(Write_Count), 0);
        check("rst_pixel", int'(Pixel_Color), 0);
        Rst = 1'b1;
        tick();

        // First write; display must not change before a frame marker.
        do_write(1, 12'hA5A, 3);
        Vertical_Split = 1'b1;
        Pixel_En = 1'b1;
        ticks(400);
        Pixel_En = 1'b0;
        ticks(2);
        check("pre_vsync", int'(Pixel_Color), 0);
        VSync = 1'b1;
        tick();
        VSync = 1'b0;
        check("vsync_edge0", int'(Pixel_Color), 0);
        ticks(3);
        model_shadow = model_work;
        check("post_vsync", int'(Pixel_Color), 12'hA5A);
        Vertical_Split = 1'b0;

        // Long C_Valid yields a single commit; re-raise gives another.
        C_Addr = 2'b10; C_Data = 12'h123; C_Valid = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (C_Rdy) pulses++;
        end
        check("hold_pulses", pulses, 1);
        C_Valid = 1'b0;
        model_work[2] = 12'h123;
        model_wc++;
        ticks(2);
        check("hold_count", int'(Write_Count), model_wc);
        do_write(2, 12'h321, 1);

        // Table of quadrant positions with all four colors loaded.
        do_write(0, 12'h00F, 1);
        do_write(1, 12'h0F0, 1);
        do_write(3, 12'hF00, 1);
        do_write(2, 12'hFFF, 2);
        foreach (vecs[i]) begin
            Vertical_Split   = vecs[i].vs;
            Horizontal_Split = vecs[i].hs;
            goto_pos(vecs[i].xs, vecs[i].ys);
            check($sformatf("vec%0d", i), int'(Pixel_Color), vecs[i].exp);
        end

        // Reset while the write is in its delay.
        Vertical_Split = 1'b0; Horizontal_Split = 1'b0;
        C_Addr = 2'b00; C_Data = 12'h123; C_Valid = 1'b1;
        tick();
        #2 Rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (C_Rdy) pulses++;
        end
        check("rst_mid_rdy", pulses, 0);
        check("rst_mid_count", int'(Write_Count), 0);
        for (int i = 0; i < 4; i++) begin
            model_work[i]   = 0;
            model_shadow[i] = 0;
        end
        model_wc = 0;
        C_Data = 12'h456;
        Rst = 1'b1;
        tick();
        lat = -1;
        for (int k = 1; k <= ACK_DELAY + 2; k++) begin
            tick();
            if (C_Rdy && lat < 0) lat = k;
        end
        check("rst_fresh_lat", lat, ACK_DELAY);
        C_Valid = 1'b0;
        ticks(2);
        model_work[0] = 12'h456;
        model_wc = 1;
        check("rst_fresh_count", int'(Write_Count), 1);
        goto_pos(0, 0);
        check("rst_fresh_lu", int'(Pixel_Color), 12'h456);
        Vertical_Split = 1'b1;
        goto_pos(400, 0);
        check("rst_cleared_ru", int'(Pixel_Color), 0);
        Vertical_Split = 1'b0;

        // Commit lands on the same edge as the shadow copy.
        C_Addr = 2'b00; C_Data = 12'hBBB; C_Valid = 1'b1;
        tick();
        VSync = 1'b1;
        tick();
        VSync = 1'b0;
        tick();
        check("coll_rdy", int'(C_Rdy), 1);
        C_Valid = 1'b0;
        ticks(3);
        model_work[0] = 12'hBBB;
        model_wc++;
        check("coll_old", int'(Pixel_Color), 12'h456);
        vsync_pulse();
        check("coll_new", int'(Pixel_Color), 12'hBBB);

        // Random writes and positions against the model.
        for (int it = 0; it < 10; it++) begin
            int a, d, xs, ys;
            bit vs, hs;
            a = $urandom_range(0, 3);
            d = $urandom_range(0, 4095);
            do_write(a, d, $urandom_range(1, 4));
            a = $urandom_range(0, 3);
            d = $urandom_range(0, 4095);
            do_write(a, d, $urandom_range(1, 4));
            vs = 1'($urandom_range(0, 1));
            hs = 1'($urandom_range(0, 1));
            xs = $urandom_range(0, 700);
            ys = $urandom_range(0, 520);
            Vertical_Split   = vs;
            Horizontal_Split = hs;
            goto_pos(xs, ys);
            check($sformatf("rand%0d", it), int'(Pixel_Color), expected_pixel(vs, hs, xs, ys));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/color_config_responder.md
# color_config_responder

Responder end of the color-configuration handshake. It accepts `C_Addr`/`C_Data` writes from the color manager under `C_Valid`/`C_Rdy`, and holds four quadrant colors. It double-buffers those colors per frame and drives the registered pixel color for the VGA path from its own X/Y position counters and the split controls.

## Interface

Parameters:
- `C_ADDR_WIDTH`, 2, quadrant address width: 00 left-up, 01 right-up, 11 right-down, 10 left-down.
- `C_DATA_WIDTH`, 12, color word width, RGB 4:4:4.
- `H_ACTIVE`, 640, active pixels per line.
- `V_ACTIVE`, 480, active lines per frame.
- `ACK_DELAY`, 2, cycles from write capture to `C_Rdy` pulse; legal range 1..15.

Ports:
- `Clk`, in, 1: single clock.
- `Rst`, in, 1: reset. Asynchronous, active-low.
- `C_Valid`, in, 1: write request from the color manager.
- `C_Addr`, in, `C_ADDR_WIDTH`: quadrant address.
- `C_Data`, in, `C_DATA_WIDTH`: color value.
- `C_Rdy`, out, 1: write-commit acknowledge, one-cycle pulse.
- `Vertical_Split`, in, 1: enables the left/right split.
- `Horizontal_Split`, in, 1: enables the up/down split.
- `Pixel_En`, in, 1: advances the X counter.
- `HSync`, in, 1: line marker; the rising edge matters.
- `VSync`, in, 1: frame marker; the rising edge matters.
- `Pixel_Color`, out, `C_DATA_WIDTH`: color of the current pixel.
- `Write_Count`, out, 8: number of committed writes, wraps.

## Operation

- Handshake FSM states:
  - IDLE: when `C_Valid`=1, latch `C_Addr`/`C_Data`, load the delay counter with `ACK_DELAY`-1, go to DELAY.
  - DELAY: decrement the counter. At 0, write the latched data into the working register selected by the latched address, pulse `C_Rdy`=1 for exactly one cycle, increment `Write_Count`, go to DROP.
  - DROP: wait for `C_Valid`=0, then return to IDLE. A `C_Valid` held high never produces a second write.
- Input changes on `C_Addr`/`C_Data` after capture are ignored.
- Four working registers hold the colors; four shadow registers drive the display. All shadows copy from the working registers on the cycle after a `VSync` rising edge is detected.
- Same-cycle write commit and shadow copy: the shadow takes the pre-write value, and the new color appears next frame.
- Edge detection: `HSync`/`VSync` are registered once; an edge is `cur & ~prev`.
- X counter:
  - Clears on an `HSync` edge.
  - Otherwise increments on `Pixel_En`.
  - Saturates at `H_ACTIVE`-1.
- Y counter:
  - Clears on a `VSync` edge.
  - Otherwise increments on an `HSync` edge.
  - Saturates at `V_ACTIVE`-1.
  - `VSync` has priority over `HSync`.
- Quadrant select:
  - right = `Vertical_Split` & (X >= `H_ACTIVE`/2).
  - down = `Horizontal_Split` & (Y >= `V_ACTIVE`/2).
  - Selected address = {down, right}.
  - With both splits off, the whole screen shows the left-up color.
- `Pixel_Color` = registered shadow[{down, right}].
- Reset mid-handshake: FSM returns to IDLE, no `C_Rdy`, no register write. If `C_Valid` is still high after reset release, that request is captured as new.

## Timing

- Reset values:
  - `C_Rdy`=0, `Write_Count`=0, `Pixel_Color`=0.
  - All working and shadow registers 0.
  - X=0, Y=0, FSM=IDLE.
  - Edge-detect registers 0.
- Write latency: `C_Valid` sampled high at edge N gives `C_Rdy`=1 during cycle N+`ACK_DELAY`. The working register updates at that same edge.
- Minimum spacing between commits: `ACK_DELAY`+2 cycles, since DROP needs at least one `C_Valid`=0 sample.
- `Pixel_Color` reflects the X/Y values one cycle earlier (1-cycle pipeline).
- Split inputs are sampled combinationally into the select and take effect on the next `Pixel_Color` update.
- Shadow visibility: a commit becomes visible 2 cycles after the next `VSync` rising edge (edge register plus copy), plus 1 cycle of output register.

## Structure

- Shared package / include file: the parameter defaults above, quadrant address constants (QUAD_LU=2'b00, QUAD_RU=2'b01, QUAD_RD=2'b11, QUAD_LD=2'b10), and FSM state encodings (IDLE, DELAY, DROP).
- Sub-module `color_quadrant_locator`: edge detection, X/Y counters and the {down, right} select, reusable by other VGA-path blocks.
- The top level holds the FSM, register bank, shadows and output register.

## Test plan

- Write 12'hA5A to addr 01, `ACK_DELAY`=2 → `C_Rdy` one pulse 2 cycles after capture, `Write_Count`=1, working[01]=12'hA5A, `Pixel_Color` unchanged until after `VSync`.
- Hold `C_Valid` high 20 cycles → exactly one `C_Rdy` pulse. Drop then raise `C_Valid` → second commit.
- Load all four quadrants (LU=12'h00F, RU=12'h0F0, RD=12'hF00, LD=12'hFFF), pulse `VSync`, both splits=1:
  - X=639, Y=0 → 12'h0F0.
  - X=0, Y=479 → 12'hFFF.
  - X=320, Y=240 → 12'hF00.
- Splits off with the same data → every position gives 12'h00F. `Vertical_Split` only at X=400, Y=400 → 12'h0F0.
- Assert `Rst`=0 during DELAY → no `C_Rdy`, register unchanged, `Write_Count` unchanged (reset value 0). After release with `C_Valid`=1 → a fresh commit `ACK_DELAY` cycles later.
- Commit a write on the same cycle as the `VSync` edge-copy → old color for this frame, new color after the following `VSync`.
